// File: rtl/fdc_pkg.sv
// Shared state encoding and default sizing for the frequency-to-digital counter sequencer.
package fdc_pkg;

  localparam int DEF_CNT_W      = 5;
  localparam int DEF_GATE_SHORT = 4;
  localparam int DEF_GATE_LONG  = 16;
  localparam int DEF_TIMEOUT    = 1023;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } fdc_state_e;

endpackage

// File: rtl/fdc_edge_det.sv
// Registered rising-edge detector: the previous level is held in a flop and compared with
// the current level.
module fdc_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/fdc_seq.sv
// Gated vco edge counter: counts vco rising edges over GATE_SHORT/GATE_LONG clk_ref periods,
// aborting with tout if clk_ref stalls for TIMEOUT cycles.
//
// state | meaning
// IDLE  | waiting for start
// ARM   | waiting for the clk_ref edge that opens the gate
// COUNT | counting vco edges until the gate closes
// DONE  | result held, valid high until ack
module fdc_seq
  import fdc_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GATE_SHORT = DEF_GATE_SHORT,
  parameter int GATE_LONG  = DEF_GATE_LONG,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             selec,
  input  logic             clk_ref,
  input  logic             vco,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             tout
);

  localparam int PER_W = $clog2(GATE_LONG + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [PER_W-1:0] GATE_S   = PER_W'(GATE_SHORT);
  localparam logic [PER_W-1:0] GATE_L   = PER_W'(GATE_LONG);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  fdc_state_e       state, state_nxt;
  logic             sel_q, sel_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             ovf_nxt, tout_nxt;
  logic [PER_W-1:0] period, period_nxt, period_inc, gate_len;
  logic [TMR_W-1:0] timer, timer_nxt, timer_inc;
  logic             ref_rise, vco_rise;

  fdc_edge_det u_ref_det (.clk(clk), .reset(reset), .din(clk_ref), .rise(ref_rise));
  fdc_edge_det u_vco_det (.clk(clk), .reset(reset), .din(vco),     .rise(vco_rise));

  assign gate_len   = sel_q ? GATE_L : GATE_S;
  assign period_inc = period + PER_W'(1);
  assign timer_inc  = timer + TMR_W'(1);
  assign busy       = (state == ARM) || (state == COUNT);
  assign valid      = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sel_q  <= 1'b0;
      count  <= '0;
      ovf    <= 1'b0;
      tout   <= 1'b0;
      period <= '0;
      timer  <= '0;
    end else begin
      state  <= state_nxt;
      sel_q  <= sel_nxt;
      count  <= count_nxt;
      ovf    <= ovf_nxt;
      tout   <= tout_nxt;
      period <= period_nxt;
      timer  <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel_q;
    count_nxt  = count;
    ovf_nxt    = ovf;
    tout_nxt   = tout;
    period_nxt = period;
    timer_nxt  = timer;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = ARM;
          sel_nxt    = selec;
          count_nxt  = '0;
          ovf_nxt    = 1'b0;
          tout_nxt   = 1'b0;
          period_nxt = '0;
          timer_nxt  = '0;
        end
      end
      ARM: begin
        timer_nxt = timer_inc;
        if (ref_rise) begin
          state_nxt = COUNT;
          timer_nxt = '0;
        end else if (timer == TMR_LAST) begin
          state_nxt = DONE;
          tout_nxt  = 1'b1;
        end
      end
      COUNT: begin
        timer_nxt = timer_inc;
        // vco is evaluated before the gate check so an edge on the closing cycle still counts
        if (vco_rise) begin
          if (count == CNT_MAX) ovf_nxt = 1'b1;
          else                  count_nxt = count + CNT_W'(1);
        end
        if (ref_rise) begin
          timer_nxt  = '0;
          period_nxt = period_inc;
          if (period_inc == gate_len) state_nxt = DONE;
        end else if (timer == TMR_LAST) begin
          state_nxt = DONE;
          tout_nxt  = 1'b1;
        end
      end
      DONE: begin
        if (ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/fdc_seq.md
FDC_SEQ -- requirements
Module: fdc_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 5, result width in bits.
REQ-002 SHALL have parameter GATE_SHORT, default 4, gate length in clk_ref periods when selec=0.
REQ-003 SHALL have parameter GATE_LONG, default 16, gate length in clk_ref periods when selec=1.
REQ-004 SHALL have parameter TIMEOUT, default 1023, maximum clk cycles allowed between clk_ref rising edges.
REQ-005 SHALL have port clk, input, 1, the single system clock; all logic uses its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, a one-cycle-or-longer request to begin a measurement.
REQ-008 SHALL have port selec, input, 1, gate select; it is sampled when the measurement starts.
REQ-009 SHALL have port clk_ref, input, 1, reference level, already synchronised to clk.
REQ-010 SHALL have port vco, input, 1, oscillator level, already synchronised to clk.
REQ-011 SHALL have port ack, input, 1, result consumed.
REQ-012 SHALL have port busy, output, 1, high in states ARM and COUNT.
REQ-013 SHALL have port valid, output, 1, result available.
REQ-014 SHALL have port count, output, CNT_W, measured number of vco rising edges.
REQ-015 SHALL have port ovf, output, 1, count saturated.
REQ-016 SHALL have port tout, output, 1, measurement aborted by timeout.

Function
REQ-017 SHALL detect rising edges of clk_ref and vco as cur & ~prev, where prev is a register updated every cycle in every state.
REQ-018 SHALL implement FSM states IDLE, ARM, COUNT and DONE, with all state changes registered.
REQ-019 In IDLE, start=1 SHALL cause a move to ARM and, in the same update, latch selec and clear count, ovf, tout, the period counter and the timer.
REQ-020 In ARM, a clk_ref edge SHALL cause a move to COUNT and clear the timer; vco edges seen while in ARM SHALL NOT be counted.
REQ-021 In COUNT, each vco edge SHALL increment count, saturating at 2^CNT_W-1.
REQ-022 In COUNT, a vco edge that arrives while count is at its maximum SHALL set ovf.
REQ-023 In COUNT, each clk_ref edge SHALL increment the period counter; the edge that makes the period counter equal the gate length SHALL cause a move to DONE.
REQ-024 A vco edge in the same cycle as the closing clk_ref edge SHALL be counted, so the measurement window is (arming edge, closing edge].
REQ-025 In ARM and COUNT, the timer SHALL increment every cycle and clear on each clk_ref edge.
REQ-026 When the timer reaches TIMEOUT, the block SHALL move to DONE with tout=1 and hold the partial count; in ARM that count is 0.
REQ-027 In DONE, valid SHALL be 1, and count, ovf and tout SHALL stay constant.
REQ-028 In DONE, ack=1 SHALL cause a move to IDLE, with valid=0 in the next cycle; ack outside DONE SHALL be ignored.
REQ-029 start while not in IDLE SHALL be ignored, including while valid=1.
REQ-030 After the closing edge, valid SHALL assert exactly 1 clk after the cycle in which that edge is detected.
REQ-031 Arithmetic SHALL be unsigned; the period counter is ceil(log2(GATE_LONG+1)) bits and the timer is ceil(log2(TIMEOUT+1)) bits.
REQ-032 If start and ack are both high, ack SHALL be applied first, so a new start is only accepted in a later IDLE cycle.

Reset
REQ-033 reset=1 SHALL force state IDLE and zero busy, valid, count, ovf, tout, the latched selec, the period counter, the timer and both edge-detector registers at the next clk edge.
REQ-034 reset SHALL take priority over every other input in every state, including in the middle of a measurement.

Structure
REQ-035 Package fdc_pkg SHALL hold the state enum and the default values of CNT_W, GATE_SHORT, GATE_LONG and TIMEOUT.
REQ-036 Sub-module fdc_edge_det (1-bit registered rising-edge detector with synchronous reset) SHALL be instantiated twice, once for clk_ref and once for vco.

Verification
REQ-037 clk_ref period 16 clk, vco period 4 clk, selec=0, pulse start -> valid=1 with count=16, ovf=0, tout=0, and busy=0 in DONE.
REQ-038 Same clocks with selec=1 -> count=31 and ovf=1 after a 16-period gate.
REQ-039 clk_ref held at 0, pulse start -> tout=1, count=0 and valid=1 exactly 1023 cycles after ARM is entered.
REQ-040 reset=1 asserted 20 cycles into COUNT -> next cycle shows IDLE with all outputs 0; a following start measures normally.
REQ-041 start pulsed while valid=1 -> no change; then ack -> valid=0 next cycle; then start -> busy=1 next cycle.
REQ-042 vco edge aligned with the closing clk_ref edge -> that edge is included in count (expected value plus 1 compared with the case where the vco edge comes 1 cycle later).
